// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single dmem port between the processor
// (fixed priority) and the graphics/game-state reader. A wait counter bounds
// graphics starvation: once graphics has been denied MAX_WAIT consecutive
// cycles, the processor is stalled for exactly one cycle (FORCE) so the
// graphics read goes through.
//
// The dmem syncram is clocked on ~clock. An address presented in cycle n is
// sampled on the falling edge of n, and dmem_q is captured into gfx_rdata on
// the rising edge that ends n. gfx_rvalid therefore pulses in cycle n+1.
//
// Ports
//   clock, reset           master clock, asynchronous active-low reset
//   cpu_req/addr/data/wren processor dmem access (wren qualified by req)
//   cpu_stall              processor holds PC/pipeline this cycle
//   gfx_req/addr           graphics read request (level-held until granted)
//   gfx_grant              graphics request accepted this cycle
//   gfx_rvalid/rdata       graphics read return, one-cycle pulse
//   dmem_addr/data/wren    to dmem syncram
//   dmem_q                 from dmem syncram
//   stat_bus               {stat_force, stat_gfx_acc, stat_cpu_acc}, only
//                          when DMEM_ARB_STATS_EN is defined
//
// Optional feature macro: DMEM_ARB_STATS_EN (access/force statistics).

module dmem_port_arbiter #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_data,
  input  logic              cpu_wren,
  output logic              cpu_stall,
  input  logic              gfx_req,
  input  logic [ADDR_W-1:0] gfx_addr,
  output logic              gfx_grant,
  output logic              gfx_rvalid,
  output logic [DATA_W-1:0] gfx_rdata,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_data,
  output logic              dmem_wren,
  input  logic [DATA_W-1:0] dmem_q
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [47:0]       stat_bus
`endif
);

  localparam int unsigned CNT_W = 8;

  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(MAX_WAIT);

  typedef enum logic [0:0] {
    ST_NORMAL = 1'b0,
    ST_FORCE  = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] wait_nxt;

  // State register.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= ST_NORMAL;
    end else begin
      state <= state_nxt;
    end
  end

  // Port ownership, stall/grant, wait counter and next state.
  // Everything is forced to zero while reset is low so no write can leak out.
  always_comb begin
    state_nxt = ST_NORMAL;
    wait_nxt  = '0;
    cpu_stall = 1'b0;
    gfx_grant = 1'b0;
    dmem_addr = '0;
    dmem_data = '0;
    dmem_wren = 1'b0;

    if (reset) begin
      if ((state == ST_FORCE) && gfx_req) begin
        // Forced graphics slot: processor held for this one cycle.
        cpu_stall = 1'b1;
        gfx_grant = 1'b1;
        dmem_addr = gfx_addr;
      end else if (cpu_req) begin
        dmem_addr = cpu_addr;
        dmem_data = cpu_data;
        dmem_wren = cpu_wren;
      end else if (gfx_req) begin
        gfx_grant = 1'b1;
        dmem_addr = gfx_addr;
      end else begin
        dmem_addr = cpu_addr;
        dmem_data = cpu_data;
      end

      // Count consecutive denied graphics cycles; any grant or a dropped
      // request leaves wait_nxt at its zero default.
      if (gfx_req && !gfx_grant) begin
        wait_nxt = (wait_cnt < WAIT_MAX) ? (wait_cnt + CNT_W'(1)) : wait_cnt;
        if ((state == ST_NORMAL) && (wait_nxt == WAIT_MAX)) begin
          state_nxt = ST_FORCE;
        end
      end
    end
  end

  // Wait counter and graphics read-return pipeline.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wait_cnt   <= '0;
      gfx_rvalid <= 1'b0;
      gfx_rdata  <= '0;
    end else begin
      wait_cnt   <= wait_nxt;
      gfx_rvalid <= gfx_grant;
      if (gfx_grant) begin
        gfx_rdata <= dmem_q;
      end
    end
  end

`ifdef DMEM_ARB_STATS_EN
  localparam int unsigned STAT_W = 16;

  logic [STAT_W-1:0] stat_cpu_acc;
  logic [STAT_W-1:0] stat_gfx_acc;
  logic [STAT_W-1:0] stat_force;
  logic              cpu_own;

  // The processor owns the port whenever it requests and is not stalled.
  assign cpu_own = cpu_req && !cpu_stall;

  // Saturating access/force counters.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stat_cpu_acc <= '0;
      stat_gfx_acc <= '0;
      stat_force   <= '0;
    end else begin
      if (cpu_own && (stat_cpu_acc != '1)) begin
        stat_cpu_acc <= stat_cpu_acc + STAT_W'(1);
      end
      if (gfx_grant && (stat_gfx_acc != '1)) begin
        stat_gfx_acc <= stat_gfx_acc + STAT_W'(1);
      end
      if ((state == ST_FORCE) && (stat_force != '1)) begin
        stat_force <= stat_force + STAT_W'(1);
      end
    end
  end

  assign stat_bus = {stat_force, stat_gfx_acc, stat_cpu_acc};
`endif

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Shares the single dmem port between the processor (primary requester) and the graphics/game-state reader (secondary requester).
- The graphics reader polls game state mirrored into dmem: level/trace number, screen indicator, end-of-game flag.
- Sits between the processor's dmem outputs and the dmem syncram, which is clocked on ~clock.
- The processor has fixed priority; a wait counter guarantees graphics forward progress by stalling the processor for one cycle when graphics has waited too long.

Parameters:
- ADDR_W, 12, dmem address width.
- DATA_W, 32, dmem data width.
- MAX_WAIT, 8, consecutive denied gfx cycles before a forced grant; legal range 1..255.

Ports:
- clock  in  1  master clock.
- reset  in  1  asynchronous, active-low reset.
- cpu_req  in  1  processor is executing lw/sw this cycle.
- cpu_addr  in  ADDR_W  processor dmem address.
- cpu_data  in  DATA_W  processor store data.
- cpu_wren  in  1  processor store enable; qualified by cpu_req.
- cpu_stall  out  1  processor must hold its PC and pipeline this cycle.
- gfx_req  in  1  graphics read request; level-held until granted.
- gfx_addr  in  ADDR_W  graphics read address; stable while gfx_req=1.
- gfx_grant  out  1  graphics request accepted this cycle.
- gfx_rvalid  out  1  gfx_rdata valid; one-cycle pulse.
- gfx_rdata  out  DATA_W  read data returned to graphics.
- dmem_addr  out  ADDR_W  to dmem address.
- dmem_data  out  DATA_W  to dmem data.
- dmem_wren  out  1  to dmem wren.
- dmem_q  in  DATA_W  from dmem q.

Behaviour:
- States: NORMAL, FORCE. Reset (reset=0, async) -> NORMAL, wait_cnt=0, gfx_rvalid=0, gfx_rdata=0.
- Combinational outputs under reset: cpu_stall=0, gfx_grant=0, dmem_wren=0, dmem_addr=0.
- NORMAL, cpu_req=1:
  - Processor owns the port: dmem_addr=cpu_addr, dmem_data=cpu_data, dmem_wren=cpu_wren.
  - gfx_grant=0, cpu_stall=0.
- NORMAL, cpu_req=0, gfx_req=1:
  - Graphics owns the port: dmem_addr=gfx_addr, dmem_wren=0, gfx_grant=1.
- NORMAL, both requests 0: dmem_addr=cpu_addr, dmem_wren=0, no grant.
- wait_cnt (8 bit):
  - Increments on every edge with gfx_req=1 and gfx_grant=0.
  - Clears on any grant, or when gfx_req=0.
  - Saturates at MAX_WAIT.
- NORMAL -> FORCE on the edge where wait_cnt reaches MAX_WAIT with gfx_req still 1.
- FORCE, lasts exactly one cycle:
  - cpu_stall=1, regardless of cpu_req.
  - Graphics owns the port, gfx_grant=1, dmem_wren=0.
  - Next state NORMAL, wait_cnt=0.
- FORCE with gfx_req dropped: graphics cannot withdraw after counting. If gfx_req=0 in FORCE, cpu_stall=0, no grant, and the state returns to NORMAL.
- Read latency:
  - Grant in cycle n: dmem samples the address on the falling edge of n.
  - gfx_rdata <= dmem_q and gfx_rvalid=1 in cycle n+1.
  - Back-to-back grants give back-to-back rvalid pulses.
- Processor loads see dmem_q directly; the arbiter does not register cpu read data.
- Reset mid-operation: a pending gfx_rvalid is discarded and wait_cnt is cleared; no dmem write is issued while reset=0.
- A stalled processor access is not lost. The processor re-presents it the following cycle; cpu_stall is the only hold mechanism.

Optional Feature:
- Macro: DMEM_ARB_STATS_EN.
- When defined, three 16-bit saturating counters are added, cleared by reset:
  - stat_cpu_acc: counts cycles with a processor grant.
  - stat_gfx_acc: counts cycles with gfx_grant.
  - stat_force: counts FORCE cycles.
- Added output port stat_bus [47:0] = {stat_force, stat_gfx_acc, stat_cpu_acc}.
- When undefined, the counters and the stat_bus port are absent; all other behaviour is identical.

Test Plan:
- Reset then idle: reset=0 mid-cycle -> all outputs 0 immediately. After release, with no requests: dmem_wren=0, gfx_rvalid=0.
- Processor store: cpu_req=1, cpu_wren=1, cpu_addr=0x004, cpu_data=0x00000003 -> dmem_addr=0x004, dmem_wren=1, cpu_stall=0. A later gfx read of 0x004 returns gfx_rdata=0x00000003 with rvalid one cycle after grant.
- Idle-slot graphics read: cpu_req=0, gfx_req=1, gfx_addr=0x006 holding 0x1 -> gfx_grant=1 same cycle, next cycle gfx_rvalid=1 and gfx_rdata=0x00000001.
- Starvation, MAX_WAIT=8: cpu_req=1 continuously, gfx_req=1 -> gfx_grant=0 for 8 cycles. The 9th cycle has cpu_stall=1 and gfx_grant=1, rvalid follows, then cpu_stall returns to 0 and wait_cnt=0.
- Back-to-back graphics reads: addresses 0x003, 0x004, 0x006 in three consecutive idle cycles -> three consecutive rvalid pulses with matching data, in order.
- Reset during FORCE: assert reset=0 in the FORCE cycle -> cpu_stall=0 and gfx_grant=0 immediately, no rvalid afterwards, state NORMAL after release.
